// File: rtl/ws_bus_master.sv
// Cartridge bus initiator: one valid/ready request becomes one nSel/nIO/nOE/nWE bus cycle.
// Latency: handshake to RespValid is SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles; accepts are spaced by that plus GAP_CYC.
// Backpressure: ReqReady is high only in IDLE; optional SClk divider is built when WS_BUS_MASTER_SCLK_EN is defined.
module ws_bus_master #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int GAP_CYC    = 1,
  parameter int SCLK_DIV   = 64
) (
  input  logic        FastClk,
  input  logic        nReset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic        ReqIO,
  input  logic [19:0] ReqAddr,
  input  logic [15:0] ReqWData,
  output logic        RespValid,
  output logic [15:0] RespRData,
  output logic        nSel,
  output logic        nIO,
  output logic        nOE,
  output logic        nWE,
  output logic [19:0] Addr,
  output logic [15:0] DataOut,
  output logic        DataOutEn,
  input  logic [15:0] DataIn,
  output logic        SClk
);

  // One shared down-counter covers every phase, so it is sized for the longest one.
  localparam int MAX_SH = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_SG = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
  localparam int MAX_PH = (MAX_SH > MAX_SG) ? MAX_SH : MAX_SG;
  localparam int CW     = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          run;
  logic          accept;
  logic          in_cycle;
  logic          cap_write;
  logic          cap_io;
  logic [19:0]   cap_addr;
  logic [15:0]   cap_wdata;
  logic [15:0]   cap_rdata;

  // ReqReady stays low until the first clock after reset release (synchronous release).
  assign ReqReady = run && (state == IDLE);
  assign accept   = ReqValid && ReqReady;

  // Marks the block as out of reset one clock after nReset rises.
  always_ff @(posedge FastClk or negedge nReset) begin
    if (!nReset) run <= 1'b0;
    else         run <= 1'b1;
  end

  // State and phase counter register.
  always_ff @(posedge FastClk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Phase sequencing: each phase reloads the counter and advances when it hits zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Request capture at the handshake; I/O cycles only carry the low byte of address and data.
  always_ff @(posedge FastClk or negedge nReset) begin
    if (!nReset) begin
      cap_write <= 1'b0;
      cap_io    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_write <= ReqWrite;
      cap_io    <= ReqIO;
      cap_addr  <= ReqIO ? {12'h000, ReqAddr[7:0]} : ReqAddr;
      if (!ReqWrite)  cap_wdata <= '0;
      else if (ReqIO) cap_wdata <= {8'h00, ReqWData[7:0]};
      else            cap_wdata <= ReqWData;
    end
  end

  // Read data is sampled on the last strobe cycle, just before nOE rises.
  always_ff @(posedge FastClk or negedge nReset) begin
    if (!nReset)                             cap_rdata <= '0;
    else if (state == STROBE && cnt == '0)   cap_rdata <= DataIn;
  end

  // Bus pins decode from state so an asynchronous reset releases every strobe at once.
  assign in_cycle  = (state == SETUP) || (state == STROBE) || (state == HOLD);
  assign nSel      = !in_cycle;
  assign nIO       = !(in_cycle && cap_io);
  assign nOE       = !((state == STROBE) && !cap_write);
  assign nWE       = !((state == STROBE) && cap_write);
  assign Addr      = cap_addr;
  assign DataOut   = cap_wdata;
  assign DataOutEn = in_cycle && cap_write;

  // Completion pulse on the first GAP cycle only.
  assign RespValid = (state == GAP) && (cnt == GAP_LD);
  assign RespRData = (RespValid && !cap_write) ? cap_rdata : 16'h0000;

`ifdef WS_BUS_MASTER_SCLK_EN
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          sclk_q;

  // Free-running serial clock divider, independent of bus activity.
  always_ff @(posedge FastClk or negedge nReset) begin
    if (!nReset) begin
      div_cnt <= '0;
      sclk_q  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      sclk_q  <= ~sclk_q;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign SClk = sclk_q;
`else
  // Without the divider SCLK_DIV has no effect; the serial clock is parked low.
  logic unused_sclk_div;
  assign unused_sclk_div = (SCLK_DIV < 1);
  assign SClk = 1'b0;
`endif

endmodule

// File: tb/tb_ws_bus_master.sv
// Directed bench for ws_bus_master with default bus timing (2/4/1/1).
// Monitor samples at the falling edge; stimulus changes 1 time unit after the rising edge.
// Build with WS_BUS_MASTER_SCLK_EN to exercise the SClk divider at SCLK_DIV=4.
module tb_ws_bus_master;

  logic        clk = 1'b0;
  logic        nReset;
  logic        ReqValid, ReqReady, ReqWrite, ReqIO;
  logic [19:0] ReqAddr;
  logic [15:0] ReqWData;
  logic        RespValid;
  logic [15:0] RespRData;
  logic        nSel, nIO, nOE, nWE;
  logic [19:0] Addr;
  logic [15:0] DataOut;
  logic        DataOutEn;
  logic [15:0] DataIn;
  logic        SClk;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor state
  int cyc = 0;
  int hs_cnt = 0, hs_last = 0, hs_prev = 0;
  int resp_cnt = 0, resp_cyc = 0;
  logic [15:0] resp_dat = '0;
  int we_run = 0, we_len = 0, oe_run = 0, oe_len = 0;
  logic we_nio = 1'b1, oe_nio = 1'b0, oe_den = 1'b0;
  logic [19:0] we_addr = '0, oe_addr = '0;
  logic [15:0] hold_dat = '0;
  logic hold_en = 1'b0, hold_sel = 1'b1;
  int sel_run = 0, last_gap = 0;
  int viol = 0;
  int sclk_hi = 0;
  logic prev_resp = 1'b0;

  ws_bus_master #(.SCLK_DIV(4)) dut (
    .FastClk(clk), .nReset(nReset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqIO(ReqIO),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespRData(RespRData),
    .nSel(nSel), .nIO(nIO), .nOE(nOE), .nWE(nWE),
    .Addr(Addr), .DataOut(DataOut), .DataOutEn(DataOutEn),
    .DataIn(DataIn), .SClk(SClk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle observation of handshakes, strobe widths, hold data and bus rules.
  always @(negedge clk) begin
    if (ReqValid && ReqReady) begin
      hs_prev = hs_last; hs_last = cyc; hs_cnt++;
    end
    if (RespValid) begin
      resp_cnt++; resp_cyc = cyc; resp_dat = RespRData;
    end
    if (!nWE) begin
      we_run++; we_nio = nIO; we_addr = Addr;
    end else if (we_run > 0) begin
      we_len = we_run; we_run = 0;
      hold_dat = DataOut; hold_en = DataOutEn; hold_sel = nSel;
    end
    if (!nOE) begin
      oe_run++; oe_nio = nIO; oe_addr = Addr; oe_den = DataOutEn;
    end else if (oe_run > 0) begin
      oe_len = oe_run; oe_run = 0;
    end
    if (nSel) sel_run++;
    else if (sel_run > 0) begin
      last_gap = sel_run; sel_run = 0;
    end
    if (!nOE && !nWE) viol++;
    if ((!nOE || !nWE) && nSel) viol++;
    if (!nOE && DataOutEn) viol++;
    if (RespValid && prev_resp) viol++;
    prev_resp = RespValid;
    if (SClk) sclk_hi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble the inputs after the handshake, wait for the response.
  task automatic run_req(input string tag, input logic wr, input logic io,
                         input logic [19:0] a, input logic [15:0] d);
    int h0, r0;
    h0 = hs_cnt;
    r0 = resp_cnt;
    @(posedge clk); #1;
    ReqValid = 1'b1; ReqWrite = wr; ReqIO = io; ReqAddr = a; ReqWData = d;
    for (int i = 0; i < 40 && hs_cnt == h0; i++) begin
      @(negedge clk); #1;
    end
    check_eq({tag, "_hs"}, hs_cnt - h0, 1);
    @(posedge clk); #1;
    ReqValid = 1'b0; ReqWrite = ~wr; ReqIO = ~io; ReqAddr = ~a; ReqWData = ~d;
    for (int i = 0; i < 40 && resp_cnt == r0; i++) begin
      @(negedge clk); #1;
    end
    check_eq({tag, "_resp"}, resp_cnt - r0, 1);
  endtask

  initial begin
    int h0, r0;
    nReset = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqIO = 1'b0;
    ReqAddr = '0; ReqWData = '0; DataIn = 16'h0000;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_nsel", nSel, 1);
    check_eq("rst_nio", nIO, 1);
    check_eq("rst_noe", nOE, 1);
    check_eq("rst_nwe", nWE, 1);
    check_eq("rst_doe", DataOutEn, 0);
    check_eq("rst_ready", ReqReady, 0);
    check_eq("rst_resp", RespValid, 0);
    check_eq("rst_addr", Addr, 0);
    check_eq("rst_dout", DataOut, 0);
    check_eq("rst_sclk", SClk, 0);

    @(posedge clk); #1;
    nReset = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_ready", ReqReady, 1);
    check_eq("idle_nsel", nSel, 1);
`ifdef WS_BUS_MASTER_SCLK_EN
    // SCLK_DIV=4: first rise on the 4th edge after release, period 8
    check_eq("sclk_e1", SClk, 0);
    for (int i = 2; i <= 12; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("sclk_e%0d", i), SClk, ((i / 4) % 2));
    end
`endif

    // I/O write: upper address bits dropped, nWE 4 cycles, data held into HOLD
    run_req("io_wr", 1'b1, 1'b1, 20'h120C1, 16'h0005);
    check_eq("io_wr_nio", we_nio, 0);
    check_eq("io_wr_addr", we_addr, 20'h000C1);
    check_eq("io_wr_we_len", we_len, 4);
    check_eq("io_wr_hold_dat", hold_dat, 16'h0005);
    check_eq("io_wr_hold_en", hold_en, 1);
    check_eq("io_wr_hold_sel", hold_sel, 0);
    check_eq("io_wr_lat", resp_cyc - hs_last, 8);
    check_eq("io_wr_rdata", resp_dat, 16'h0000);

    // memory read: DataIn only valid from the strobe onward
    DataIn = 16'hDEAD;
    fork
      begin @(negedge nOE); DataIn = 16'hBEEF; end
    join_none
    run_req("rd1", 1'b0, 1'b0, 20'hFFFF0, 16'h0000);
    check_eq("rd1_oe_len", oe_len, 4);
    check_eq("rd1_nio", oe_nio, 1);
    check_eq("rd1_addr", oe_addr, 20'hFFFF0);
    check_eq("rd1_doe", oe_den, 0);
    check_eq("rd1_lat", resp_cyc - hs_last, 8);
    check_eq("rd1_rdata", resp_dat, 16'hBEEF);

    // read again; DataIn changes right as nOE rises, capture must keep 0xBEEF
    DataIn = 16'hBEEF;
    fork
      begin @(posedge nOE); DataIn = 16'h1234; end
    join_none
    run_req("rd2", 1'b0, 1'b0, 20'hFFFF0, 16'h0000);
    check_eq("rd2_rdata", resp_dat, 16'hBEEF);

    // back-to-back reads with ReqValid held high
    h0 = hs_cnt;
    r0 = resp_cnt;
    @(posedge clk); #1;
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqIO = 1'b0; ReqAddr = 20'h00400;
    for (int i = 0; i < 60 && hs_cnt < h0 + 2; i++) begin
      @(negedge clk); #1;
    end
    check_eq("b2b_hs", hs_cnt - h0, 2);
    check_eq("b2b_spacing", hs_last - hs_prev, 9);
    @(posedge clk); #1;
    ReqValid = 1'b0;
    for (int i = 0; i < 40 && resp_cnt < r0 + 2; i++) begin
      @(negedge clk); #1;
    end
    check_eq("b2b_resp", resp_cnt - r0, 2);
    check_eq("b2b_nsel_gap", last_gap, 2);
    check_eq("b2b_rdata", resp_dat, 16'h1234);

    // reset during the strobe of a write
    h0 = hs_cnt;
    @(posedge clk); #1;
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqIO = 1'b0; ReqAddr = 20'h00010; ReqWData = 16'hA5A5;
    for (int i = 0; i < 40 && hs_cnt == h0; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    ReqValid = 1'b0;
    for (int i = 0; i < 40 && nWE; i++) begin
      @(negedge clk); #1;
    end
    check_eq("abort_we_low", nWE, 0);
    r0 = resp_cnt;
    @(negedge clk); #1;
    nReset = 1'b0;
    #1;
    check_eq("abort_nwe", nWE, 1);
    check_eq("abort_nsel", nSel, 1);
    check_eq("abort_doe", DataOutEn, 0);
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_no_resp", resp_cnt - r0, 0);
    run_req("post_wr", 1'b1, 1'b0, 20'h00020, 16'h5A5A);
    check_eq("post_wr_lat", resp_cyc - hs_last, 8);
    check_eq("post_wr_hold_dat", hold_dat, 16'h5A5A);
    check_eq("post_wr_addr", we_addr, 20'h00020);

    // idle stretch, then bus rule and serial clock summaries
    sclk_hi = 0;
    repeat (1000) @(posedge clk);
    @(negedge clk); #1;
    check_eq("bus_rules", viol, 0);
`ifdef WS_BUS_MASTER_SCLK_EN
    check_eq("sclk_toggles", (sclk_hi > 400) && (sclk_hi < 600), 1);
`else
    check_eq("sclk_tied_low", sclk_hi, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
